// File: rtl/tanh_act_seq.sv
// Requester side of the 8-bit tanh LUT: quantizes signed accumulators to LUT addresses,
// captures the LUT result and streams activations out with vector-boundary tagging.
module tanh_act_seq #(
    parameter int N     = 8,
    parameter int ACC_W = 16,
    parameter int SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_acc,
    input  logic                    in_last,
    output logic [7:0]              lut_addr,
    input  logic [7:0]              lut_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              out_data,
    output logic                    out_last,
    output logic [15:0]             sat_cnt,
    output logic                    err,
    input  logic                    clr
);

    localparam int IDX_W = $clog2(N);
    localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-128);

    logic             a_valid;
    logic             a_last;
    logic [IDX_W-1:0] idx;

    logic signed [ACC_W-1:0] q;
    logic             clip_hi;
    logic             clip_lo;
    logic [7:0]       q_addr;
    logic             adv;
    logic             load;
    logic             idx_last;
    logic             clip;
    logic             mismatch;

    assign q        = in_acc >>> SHIFT;
    assign clip_hi  = (q > Q_MAX);
    assign clip_lo  = (q < Q_MIN);
    assign adv      = a_valid && (!out_valid || out_ready);
    assign in_ready = !a_valid || adv;
    assign load     = in_valid && in_ready;
    assign idx_last = (idx == IDX_W'(N - 1));
    assign clip     = load && (clip_hi || clip_lo);
    assign mismatch = load && (in_last != idx_last);

    always_comb begin
        q_addr = q[7:0];
        if (clip_hi) begin
            q_addr = 8'h7F;
        end else if (clip_lo) begin
            q_addr = 8'h80;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid   <= 1'b0;
            a_last    <= 1'b0;
            lut_addr  <= 8'h00;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            sat_cnt   <= 16'd0;
            err       <= 1'b0;
        end else begin
            // lut_addr only moves on a load so the LUT output stays valid across a stall
            if (load) begin
                a_valid  <= 1'b1;
                a_last   <= idx_last;
                lut_addr <= q_addr;
                if (idx_last || in_last) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end else if (adv) begin
                a_valid <= 1'b0;
            end

            if (adv) begin
                out_valid <= 1'b1;
                out_data  <= lut_data;
                out_last  <= a_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            // a clip or mismatch in the same cycle as clr survives the clear
            if (clr) begin
                sat_cnt <= clip ? 16'd1 : 16'd0;
            end else if (clip && (sat_cnt != 16'hFFFF)) begin
                sat_cnt <= sat_cnt + 16'd1;
            end

            if (clr) begin
                err <= mismatch;
            end else if (mismatch) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tanh_act_seq.sv
// Bench for tanh_act_seq: behavioural tanh LUT on the falling edge, scoreboard of
// expected activations pushed on input acceptance and popped on output handshakes.
module tb_tanh_act_seq;

    localparam int N     = 8;
    localparam int ACC_W = 16;
    localparam int SHIFT = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ACC_W-1:0] in_acc;
    logic                    in_last;
    logic [7:0]              lut_addr;
    logic [7:0]              lut_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              out_data;
    logic                    out_last;
    logic [15:0]             sat_cnt;
    logic                    err;
    logic                    clr;

    int checks = 0;
    int fails  = 0;
    int pops   = 0;

    logic [8:0] sb[$];
    int         exp_idx = 0;
    logic       stalled = 1'b0;
    logic [8:0] held;

    tanh_act_seq #(.N(N), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc), .in_last(in_last),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sat_cnt(sat_cnt), .err(err), .clr(clr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] quant(input logic [15:0] acc);
        int q;
        q = $signed(acc) >>> SHIFT;
        if (q > 127) return 8'h7F;
        if (q < -128) return 8'h80;
        return 8'(q);
    endfunction

    // tanh-like LUT: 7/16 slope truncated toward zero, clamped at +/-48
    function automatic logic [7:0] lut_fn(input logic [7:0] a);
        int v;
        v = $signed(a);
        v = (v * 7) / 16;
        if (v > 48) v = 48;
        if (v < -48) v = -48;
        return 8'(v);
    endfunction

    initial lut_data = 8'h00;
    always @(negedge clk) lut_data = lut_fn(lut_addr);

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if ({out_valid, out_last, out_data} !== {1'b1, held}) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%0b last=%0b data=%02h, need v=1 last=%0b data=%02h",
                             out_valid, out_last, out_data, held[8], held[7:0]);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                pops++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL out_unexpected: got last=%0b data=%02h, need no beat", out_last, out_data);
                end else begin
                    logic [8:0] e;
                    e = sb.pop_front();
                    if ({out_last, out_data} !== e) begin
                        fails++;
                        $display("FAIL out_beat: got last=%0b data=%02h, need last=%0b data=%02h",
                                 out_last, out_data, e[8], e[7:0]);
                    end
                end
            end
            stalled = out_valid && !out_ready;
            held    = {out_last, out_data};
            if (in_valid && in_ready) begin
                logic l;
                l = (exp_idx == N - 1);
                sb.push_back({l, lut_fn(quant(in_acc))});
                exp_idx = (l || in_last) ? 0 : exp_idx + 1;
            end
        end
    end

    task automatic send(input logic [15:0] acc, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_acc   = acc;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: got in_ready=0 after %0d cycles, need 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0) && n < 300) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d beats outstanding, need 0", sb.size());
        end
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        clr      = 1'b0;
        sb.delete();
        exp_idx = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_acc    = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        clr       = 1'b0;
        #1;
        checks++;
        if ({lut_addr, out_data, sat_cnt} !== 32'h0) begin
            fails++;
            $display("FAIL reset_regs: got addr=%02h data=%02h sat=%0d, need 0/0/0", lut_addr, out_data, sat_cnt);
        end
        checks++;
        if ({out_valid, out_last, err, in_ready} !== 4'b0001) begin
            fails++;
            $display("FAIL reset_flags: got v/last/err/rdy=%04b, need 0001", {out_valid, out_last, err, in_ready});
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL reset_after: got v/rdy=%02b, need 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        send(16'h0100, 1'b0);
        checks++;
        if (lut_addr !== 8'h10) begin
            fails++;
            $display("FAIL single_addr: got %02h, need 10", lut_addr);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_early: got out_valid=%0b at E0, need 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_data} !== {1'b1, 8'h07}) begin
            fails++;
            $display("FAIL single_out: got v=%0b data=%02h, need v=1 data=07", out_valid, out_data);
        end
        checks++;
        if (sat_cnt !== 16'd0) begin
            fails++;
            $display("FAIL single_sat: got %0d, need 0", sat_cnt);
        end
        drain();
    endtask

    task automatic test_saturation();
        pulse_clr();
        send(16'h7FFF, 1'b0);
        checks++;
        if (lut_addr !== 8'h7F) begin
            fails++;
            $display("FAIL sat_addr_hi: got %02h, need 7F", lut_addr);
        end
        send(16'h8000, 1'b0);
        checks++;
        if ({lut_addr, out_data} !== {8'h80, 8'h30}) begin
            fails++;
            $display("FAIL sat_hi_out: got addr=%02h data=%02h, need 80/30", lut_addr, out_data);
        end
        checks++;
        if (sat_cnt !== 16'd2) begin
            fails++;
            $display("FAIL sat_cnt: got %0d, need 2", sat_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_data !== 8'hD0) begin
            fails++;
            $display("FAIL sat_lo_out: got %02h, need D0", out_data);
        end
        drain();
    endtask

    task automatic test_negative();
        send(16'hFFF0, 1'b0);
        checks++;
        if (lut_addr !== 8'hFF) begin
            fails++;
            $display("FAIL neg_addr: got %02h, need FF", lut_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_data !== 8'h00) begin
            fails++;
            $display("FAIL neg_out: got %02h, need 00", out_data);
        end
        send(16'hF800, 1'b0);
        checks++;
        if (lut_addr !== 8'h80) begin
            fails++;
            $display("FAIL neg128_addr: got %02h, need 80", lut_addr);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_data, sat_cnt} !== {8'hD0, 16'd2}) begin
            fails++;
            $display("FAIL neg128_out: got data=%02h sat=%0d, need D0/2", out_data, sat_cnt);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int p0;
        apply_reset();
        out_ready = 1'b1;
        p0 = pops;
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send(16'(i * 300 - 2400), (i % 8) == 7);
                end
            end
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        checks++;
        if (pops - p0 !== 16) begin
            fails++;
            $display("FAIL stream_count: got %0d outputs, need 16", pops - p0);
        end
        checks++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL stream_err: got %0b, need 0", err);
        end
    endtask

    task automatic test_length_mismatch();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) send(16'(i * 64), i == 5);
        checks++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL mismatch_err: got %0b, need 1", err);
        end
        for (int i = 0; i < 8; i++) send(16'(i * 100 + 16), i == 7);
        drain();
        pulse_clr();
        checks++;
        if ({err, sat_cnt} !== 17'd0) begin
            fails++;
            $display("FAIL clr: got err=%0b sat=%0d, need 0/0", err, sat_cnt);
        end
        clr = 1'b1;
        send(16'h7FFF, 1'b0);
        clr = 1'b0;
        checks++;
        if (sat_cnt !== 16'd1) begin
            fails++;
            $display("FAIL clr_clip: got sat=%0d, need 1", sat_cnt);
        end
        clr = 1'b1;
        send(16'h0040, 1'b1);
        clr = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL clr_mismatch: got err=%0b, need 1", err);
        end
        drain();
    endtask

    task automatic test_reset_midstream();
        int p0;
        apply_reset();
        out_ready = 1'b0;
        send(16'h0200, 1'b0);
        send(16'h0300, 1'b0);
        checks++;
        if ({out_valid, in_ready} !== 2'b10) begin
            fails++;
            $display("FAIL mid_full: got v/rdy=%02b, need 10", {out_valid, in_ready});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            fails++;
            $display("FAIL mid_reset: got v/rdy=%02b, need 01", {out_valid, in_ready});
        end
        sb.delete();
        exp_idx = 0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_ghost: got out_valid=%0b, need 0", out_valid);
        end
        p0 = pops;
        for (int i = 0; i < 8; i++) send(16'(-i * 200), i == 7);
        drain();
        checks++;
        if ({pops - p0, err} !== {32'd8, 1'b0}) begin
            fails++;
            $display("FAIL mid_vector: got %0d outputs err=%0b, need 8/0", pops - p0, err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_negative();
        test_back_to_back();
        test_length_mismatch();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, need finish");
        $fatal(1, "watchdog");
    end

endmodule
